// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI slave bridge.
// Holds the frame FSM state encoding, the tag-nibble width and the bit
// offsets of the status word fields, counted down from the word MSB
// (field bit = WORD_W - offset).
package spi_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_e;

    // Upper nibble of a received word; all-zero tag marks a dummy word.
    localparam int TAG_W = 4;

    // Status word layout, offsets from the MSB end of the word.
    localparam int STAT_MARK_OFS = 5;   // constant one: identifies a status word
    localparam int STAT_REQ_OFS  = 6;   // word was sent in answer to a cntreq toggle
    localparam int STAT_TXE_OFS  = 7;   // TX FIFO empty
    localparam int STAT_OVF_OFS  = 8;   // sticky RX overflow
    localparam int STAT_FERR_OFS = 9;   // sticky frame error
    localparam int STAT_HDR_W    = 9;   // bits above the occupancy field

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (empties FIFO)
//   push, din       - write request and data; ignored while full
//   pop             - read request; ignored while empty
//   dout            - head word, valid while !empty, zero when empty
//   full, empty     - registered status flags
//   count           - current occupancy in words (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push & ~full_r;
    assign pop_ok_s  = pop & ~empty_r;

    // Occupancy after this cycle's accepted push/pop; both together cancel.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == {CW{1'b0}});
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = empty_r ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/spi_slave_bridge.sv
// SPI slave to core bridge with a TX (core->SPI) and RX (SPI->core) FIFO.
// Ports:
//   clk, rst                  - system clock, synchronous active-high reset
//   spi_clk, spi_mosi, spi_cs - asynchronous SPI inputs (spi_cs active low)
//   spi_miso                  - SPI data out
//   gpio_rd_valid             - TX FIFO holds at least one word
//   gpio_rd_urgent            - TX occupancy >= URGENT_LVL
//   gpio_rd_cntreq            - host toggle requesting a status word
//   wr_en, wr_din, wr_full    - core write side of the TX FIFO
//   rd_en, rd_rdy, rd_dout    - core FWFT read side of the RX FIFO
//   rx_overflow, frame_err    - sticky errors, cleared by rst or a served status word
// Each frame sends one word: a requested status word, else the TX head,
// else an unrequested status word. Received words with a zero tag nibble
// are treated as dummies and dropped.
module spi_slave_bridge
    import spi_bridge_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int TX_DEPTH   = 512,
    parameter int RX_DEPTH   = 16,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int URGENT_LVL = TX_DEPTH * 3 / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    output logic              spi_miso,
    output logic              gpio_rd_valid,
    output logic              gpio_rd_urgent,
    input  logic              gpio_rd_cntreq,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_din,
    output logic              wr_full,
    input  logic              rd_en,
    output logic              rd_rdy,
    output logic [WORD_W-1:0] rd_dout,
    output logic              rx_overflow,
    output logic              frame_err
);

    localparam int TX_CW  = $clog2(TX_DEPTH + 1);
    localparam int RX_CW  = $clog2(RX_DEPTH + 1);
    localparam int BIT_CW = $clog2(WORD_W + 1);
    localparam int OCC_W  = WORD_W - STAT_HDR_W;

    // Synchroniser chains: index 1 is the synchronised copy, index 2 its
    // previous value for edge detection. They carry no reset so that a
    // reset while spi_cs is low cannot fake a chip-select edge.
    logic [2:0] sclk_sync_r;
    logic [2:0] cs_sync_r;
    logic [1:0] mosi_sync_r;
    logic [1:0] cntreq_sync_r;

    spi_state_e        state_r;
    spi_state_e        state_nxt_s;
    logic [WORD_W-1:0] rx_sr_r;
    logic [WORD_W-1:0] tx_sr_r;
    logic [BIT_CW-1:0] bit_cnt_r;
    logic              miso_r;
    logic              served_r;
    logic              rx_overflow_r;
    logic              frame_err_r;
    logic              urgent_r;

    logic              sclk_rise_s, sclk_fall_s, lead_s, trail_s;
    logic              sample_edge_s, out_edge_s;
    logic              cs_fall_s, cs_rise_s;
    logic              cntreq_pend_s;
    logic [WORD_W-1:0] status_s;
    logic [OCC_W-1:0]  occ_field_s;
    logic [WORD_W-1:0] tx_word_s;
    logic              tx_pop_s, send_req_s, rx_push_s, ovf_set_s, ferr_set_s;
    logic              bit_full_s;

    logic [WORD_W-1:0] tx_dout_s;
    logic              tx_full_s, tx_empty_s;
    logic [TX_CW-1:0]  tx_count_s;
    logic              rx_full_s, rx_empty_s;
    logic [RX_CW-1:0]  rx_count_s;

    // Bring asynchronous SPI pins and the cntreq toggle into the clk domain.
    always_ff @(posedge clk) begin
        sclk_sync_r   <= {sclk_sync_r[1:0], spi_clk};
        cs_sync_r     <= {cs_sync_r[1:0], spi_cs};
        mosi_sync_r   <= {mosi_sync_r[0], spi_mosi};
        cntreq_sync_r <= {cntreq_sync_r[0], gpio_rd_cntreq};
    end

    assign sclk_rise_s   = sclk_sync_r[1] & ~sclk_sync_r[2];
    assign sclk_fall_s   = ~sclk_sync_r[1] & sclk_sync_r[2];
    assign lead_s        = (CPOL == 0) ? sclk_rise_s : sclk_fall_s;
    assign trail_s       = (CPOL == 0) ? sclk_fall_s : sclk_rise_s;
    assign sample_edge_s = (CPHA == 0) ? lead_s : trail_s;
    assign out_edge_s    = (CPHA == 0) ? trail_s : lead_s;
    assign cs_fall_s     = ~cs_sync_r[1] & cs_sync_r[2];
    assign cs_rise_s     = cs_sync_r[1] & ~cs_sync_r[2];
    assign cntreq_pend_s = cntreq_sync_r[1] ^ served_r;
    assign bit_full_s    = (bit_cnt_r == BIT_CW'(WORD_W));

    // Occupancy field: zero-extend when it fits, otherwise saturate.
    if (TX_CW <= OCC_W) begin : g_occ_ext
        assign occ_field_s = OCC_W'(tx_count_s);
    end else begin : g_occ_sat
        assign occ_field_s = (tx_count_s > TX_CW'({OCC_W{1'b1}})) ?
                             {OCC_W{1'b1}} : tx_count_s[OCC_W-1:0];
    end

    // Assemble the status word from the current flags and TX occupancy.
    always_comb begin
        status_s                          = {WORD_W{1'b0}};
        status_s[WORD_W - STAT_MARK_OFS]  = 1'b1;
        status_s[WORD_W - STAT_REQ_OFS]   = cntreq_pend_s;
        status_s[WORD_W - STAT_TXE_OFS]   = tx_empty_s;
        status_s[WORD_W - STAT_OVF_OFS]   = rx_overflow_r;
        status_s[WORD_W - STAT_FERR_OFS]  = frame_err_r;
        status_s[OCC_W-1:0]               = occ_field_s;
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame FSM next state plus LOAD word selection and DONE disposition.
    always_comb begin
        state_nxt_s = state_r;
        tx_pop_s    = 1'b0;
        send_req_s  = 1'b0;
        tx_word_s   = status_s;
        rx_push_s   = 1'b0;
        ovf_set_s   = 1'b0;
        ferr_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cntreq_pend_s) begin
                    send_req_s = 1'b1;
                end else if (!tx_empty_s) begin
                    tx_pop_s  = 1'b1;
                    tx_word_s = tx_dout_s;
                end else begin
                    tx_word_s = status_s;
                end
                if (cs_rise_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (bit_full_s) begin
                    if (rx_sr_r[WORD_W-1 -: TAG_W] != {TAG_W{1'b0}}) begin
                        if (rx_full_s) begin
                            ovf_set_s = 1'b1;
                        end else begin
                            rx_push_s = 1'b1;
                        end
                    end else begin
                        rx_push_s = 1'b0;
                    end
                end else begin
                    ferr_set_s = 1'b1;
                end
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Shift registers, bit counter and MISO; MSB is driven out in LOAD so
    // CPHA=0 masters see it before the first sample edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr_r   <= {WORD_W{1'b0}};
            tx_sr_r   <= {WORD_W{1'b0}};
            bit_cnt_r <= {BIT_CW{1'b0}};
            miso_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    rx_sr_r   <= {WORD_W{1'b0}};
                    bit_cnt_r <= {BIT_CW{1'b0}};
                    miso_r    <= tx_word_s[WORD_W-1];
                    tx_sr_r   <= (CPHA == 0) ? {tx_word_s[WORD_W-2:0], 1'b0} : tx_word_s;
                end
                ST_SHIFT: begin
                    // Once WORD_W bits are in, MOSI is ignored and zeros go out.
                    if (sample_edge_s && !bit_full_s) begin
                        rx_sr_r   <= {rx_sr_r[WORD_W-2:0], mosi_sync_r[1]};
                        bit_cnt_r <= bit_cnt_r + BIT_CW'(1);
                    end
                    if (out_edge_s) begin
                        miso_r  <= bit_full_s ? 1'b0 : tx_sr_r[WORD_W-1];
                        tx_sr_r <= {tx_sr_r[WORD_W-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    miso_r <= 1'b0;
                end
                default: begin
                    miso_r <= miso_r;
                end
            endcase
        end
    end

    // Sticky flags, served-cntreq record and urgent level.
    always_ff @(posedge clk) begin
        if (rst) begin
            served_r      <= cntreq_sync_r[1];
            rx_overflow_r <= 1'b0;
            frame_err_r   <= 1'b0;
            urgent_r      <= 1'b0;
        end else begin
            urgent_r <= (tx_count_s >= TX_CW'(URGENT_LVL));
            if (send_req_s) begin
                served_r      <= cntreq_sync_r[1];
                rx_overflow_r <= 1'b0;
                frame_err_r   <= 1'b0;
            end else begin
                if (ovf_set_s) begin
                    rx_overflow_r <= 1'b1;
                end
                if (ferr_set_s) begin
                    frame_err_r <= 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .din   (wr_din),
        .pop   (tx_pop_s),
        .dout  (tx_dout_s),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s)
    );

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push_s),
        .din   (rx_sr_r),
        .pop   (rd_en),
        .dout  (rd_dout),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .count (rx_count_s)
    );

    assign spi_miso       = miso_r;
    assign gpio_rd_valid  = ~tx_empty_s;
    assign gpio_rd_urgent = urgent_r;
    assign wr_full        = tx_full_s;
    assign rd_rdy         = ~rx_empty_s;
    assign rx_overflow    = rx_overflow_r;
    assign frame_err      = frame_err_r;

endmodule

// File: tb/tb_spi_slave_bridge.sv
// Self-checking bench: four bridges (one per SPI mode, TX_DEPTH=8,
// RX_DEPTH=4) driven by a bench SPI master. Expected MISO words and RX
// read data are queued when stimulus is issued; a monitor compares them
// as frames complete and as the core pops words.
module tb_spi_slave_bridge;

    localparam int HALF = 5;   // spi_clk half period in clk cycles

    typedef struct {
        string       nm;
        logic [31:0] v;
        int          m;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mosi = 1'b0;
    logic        cntreq = 1'b0;
    logic [31:0] wr_din = 32'h0;
    logic [3:0]  sclk_v = 4'b1100;
    logic [3:0]  cs_v = 4'b1111;
    logic [3:0]  wr_en_v = 4'b0000;
    logic [3:0]  rd_en_v = 4'b0000;
    logic [3:0]  miso_v, valid_v, urg_v, wr_full_v, rd_rdy_v, ovf_v, ferr_v;
    logic [31:0] dout_a [4];

    int n_chk = 0;
    int n_fail = 0;
    exp_t mi_exp_q[$];
    exp_t rd_exp_q[$];
    logic [31:0] mi_obs_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_bridge #(
            .WORD_W   (32),
            .TX_DEPTH (8),
            .RX_DEPTH (4),
            .CPOL     (g / 2),
            .CPHA     (g % 2)
        ) dut (
            .clk            (clk),
            .rst            (rst),
            .spi_clk        (sclk_v[g]),
            .spi_mosi       (mosi),
            .spi_cs         (cs_v[g]),
            .spi_miso       (miso_v[g]),
            .gpio_rd_valid  (valid_v[g]),
            .gpio_rd_urgent (urg_v[g]),
            .gpio_rd_cntreq (cntreq),
            .wr_en          (wr_en_v[g]),
            .wr_din         (wr_din),
            .wr_full        (wr_full_v[g]),
            .rd_en          (rd_en_v[g]),
            .rd_rdy         (rd_rdy_v[g]),
            .rd_dout        (dout_a[g]),
            .rx_overflow    (ovf_v[g]),
            .frame_err      (ferr_v[g])
        );
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Inputs change 2 ns after a rising edge, away from sampling points.
    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_outs(string nm);
        chk(nm, {miso_v, valid_v, urg_v, wr_full_v, rd_rdy_v, ovf_v, ferr_v}, 64'h0);
        chk({nm, "_dout"}, dout_a[0], 64'h0);
    endtask

    task automatic wr_word(int m, logic [31:0] d);
        wr_din = d;
        wr_en_v[m] = 1'b1;
        step(1);
        wr_en_v[m] = 1'b0;
    endtask

    task automatic rd_word(int m);
        rd_en_v[m] = 1'b1;
        step(1);
        rd_en_v[m] = 1'b0;
        step(1);
    endtask

    task automatic toggle_cntreq();
        cntreq = ~cntreq;
        step(4);
    endtask

    // Bench SPI master: nbits clocks on slave m; rst pulsed before bit rst_at.
    task automatic spi_frame(int m, logic [31:0] mo, int nbits, int rst_at,
                             output logic [31:0] mi);
        logic p;
        logic h;
        p  = (m / 2) != 0;
        h  = (m % 2) != 0;
        mi = 32'h0;
        if (!h) mosi = mo[31];
        cs_v[m] = 1'b0;
        step(8);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                step(3);
                chk_reset_outs("rst_mid_frame");
                rst = 1'b0;
                step(1);
            end
            if (!h) mi = {mi[30:0], miso_v[m]};
            sclk_v[m] = ~p;
            if (h) mosi = mo[31-i];
            step(HALF);
            if (h) mi = {mi[30:0], miso_v[m]};
            sclk_v[m] = p;
            if (!h && i < 31) mosi = mo[30-i];
            step(HALF);
        end
        step(2);
        cs_v[m] = 1'b1;
        step(8);
    endtask

    // Full 32-bit frame whose MISO word goes to the scoreboard.
    task automatic xfer(string nm, int m, logic [31:0] mo, logic [31:0] exp);
        logic [31:0] w;
        mi_exp_q.push_back('{nm, exp, m});
        spi_frame(m, mo, 32, -1, w);
        mi_obs_q.push_back(w);
    endtask

    // Scoreboard monitor: completed MISO words and core-side RX pops.
    always @(negedge clk) begin
        exp_t e;
        while (mi_obs_q.size() > 0) begin
            if (mi_exp_q.size() == 0) begin
                chk("miso_unexpected", mi_obs_q.pop_front(), 64'hx);
            end else begin
                e = mi_exp_q.pop_front();
                chk(e.nm, mi_obs_q.pop_front(), e.v);
            end
        end
        for (int m = 0; m < 4; m++) begin
            if (rd_en_v[m] && rd_rdy_v[m]) begin
                if (rd_exp_q.size() == 0) begin
                    chk("rd_unexpected", dout_a[m], 64'hx);
                end else begin
                    e = rd_exp_q.pop_front();
                    chk({e.nm, "_dut"}, m, e.m);
                    chk(e.nm, dout_a[m], e.v);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] junk;
        step(6);
        rst = 1'b0;
        step(2);
        chk_reset_outs("reset_state");

        // TX word returned on MISO in every SPI mode; dummy MOSI not pushed.
        for (int m = 0; m < 4; m++) begin
            wr_word(m, 32'h1234_5678);
            step(1);
            chk($sformatf("valid_after_wr_m%0d", m), valid_v[m], 64'h1);
            xfer($sformatf("miso_data_m%0d", m), m, 32'h0000_0001, 32'h1234_5678);
            chk($sformatf("valid_after_frame_m%0d", m), valid_v[m], 64'h0);
            chk($sformatf("no_rx_push_m%0d", m), rd_rdy_v[m], 64'h0);
            chk($sformatf("no_ferr_m%0d", m), ferr_v[m], 64'h0);
        end

        // Requested status (27,26,25 = mark, req, tx_empty), then unrequested.
        toggle_cntreq();
        xfer("status_req_empty", 0, 32'h0, 32'h0E00_0000);
        xfer("status_plain_empty", 0, 32'h0, 32'h0A00_0000);

        // Tagged MOSI word reaches the core read side.
        xfer("miso_status_rx", 0, 32'hA000_0001, 32'h0A00_0000);
        chk("rd_rdy_after_push", rd_rdy_v[0], 64'h1);
        chk("rd_dout_fwft", dout_a[0], 64'hA000_0001);
        rd_exp_q.push_back('{"rd_a0000001", 32'hA000_0001, 0});
        rd_word(0);
        chk("rd_rdy_after_pop", rd_rdy_v[0], 64'h0);

        // Five tagged words into a 4-deep RX FIFO: last one dropped.
        for (int i = 0; i < 5; i++) begin
            xfer("miso_ovf_seq", 0, 32'h1000_0000 + i, 32'h0A00_0000);
            if (i < 4) rd_exp_q.push_back('{$sformatf("rd_ovf_%0d", i), 32'h1000_0000 + i, 0});
        end
        chk("rx_overflow_set", ovf_v[0], 64'h1);
        toggle_cntreq();
        xfer("status_ovf", 0, 32'h0, 32'h0F00_0000);
        chk("rx_overflow_cleared", ovf_v[0], 64'h0);
        for (int i = 0; i < 5; i++) rd_word(0);
        chk("rx_drained", rd_rdy_v[0], 64'h0);

        // Short frame: popped TX word lost, frame error, no RX push.
        wr_word(0, 32'hCAFE_F00D);
        spi_frame(0, 32'hA5A5_A5A5, 20, -1, junk);
        chk("frame_err_set", ferr_v[0], 64'h1);
        chk("short_no_rx", rd_rdy_v[0], 64'h0);
        chk("short_tx_popped", valid_v[0], 64'h0);
        toggle_cntreq();
        xfer("status_ferr", 0, 32'h0, 32'h0E80_0000);
        chk("frame_err_cleared", ferr_v[0], 64'h0);

        // Urgent level 6 of 8, full at 8, ninth write ignored.
        for (int i = 0; i < 5; i++) wr_word(0, 32'h5000_0000 + i);
        step(2);
        chk("urgent_below", urg_v[0], 64'h0);
        wr_word(0, 32'h5000_0005);
        step(2);
        chk("urgent_at_level", urg_v[0], 64'h1);
        wr_word(0, 32'h5000_0006);
        wr_word(0, 32'h5000_0007);
        step(1);
        chk("wr_full_set", wr_full_v[0], 64'h1);
        wr_word(0, 32'hDEAD_BEEF);
        toggle_cntreq();
        xfer("status_occ8", 0, 32'h0, 32'h0C00_0008);
        for (int i = 0; i < 8; i++) xfer("miso_tx_seq", 0, 32'h0, 32'h5000_0000 + i);
        xfer("status_after_drain", 0, 32'h0, 32'h0A00_0000);

        // Reset in the middle of a frame, then a normal frame.
        wr_word(0, 32'h1234_5678);
        spi_frame(0, 32'hA5A5_A5A5, 32, 10, junk);
        chk("abort_no_rx", rd_rdy_v[0], 64'h0);
        chk("abort_no_ferr", ferr_v[0], 64'h0);
        wr_word(0, 32'h1234_5678);
        xfer("miso_after_rst", 0, 32'hB000_0002, 32'h1234_5678);
        rd_exp_q.push_back('{"rd_after_rst", 32'hB000_0002, 0});
        rd_word(0);

        step(4);
        chk("scoreboard_drained", mi_exp_q.size() + rd_exp_q.size() + mi_obs_q.size(), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
